// File: rtl/frame_scheduler_pkg.sv
// Shared types for the frame scheduler: FSM states and coordinate format.
package frame_scheduler_pkg;

    localparam int COORD_FRAC  = 20;
    localparam int COORD_W_DEF = 27;
    localparam int ROW_W       = 10;

    typedef logic signed [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/frame_scheduler_rr_arbiter.sv
// Round-robin pick: first eligible requester at or above ptr, wrapping past N-1.
module rr_arbiter #(
    parameter int N  = 10,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] index,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] j;

    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        sum    = '0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract performs the wrap
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            j = sum[PW-1:0];
            if (!any && eligible[j]) begin
                any       = 1'b1;
                index     = j;
                winner[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Dispatches the rows of one frame to idle solvers, one grant per cycle,
// tracks outstanding rows and times the frame.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int NUM_SOLVERS = 10,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COORD_W     = COORD_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [COORD_W-1:0] min_x,
    input  logic signed [COORD_W-1:0] min_y,
    input  logic signed [COORD_W-1:0] dx,
    input  logic signed [COORD_W-1:0] dy,
    input  logic [NUM_SOLVERS-1:0]    req,
    input  logic [NUM_SOLVERS-1:0]    row_done,
    output logic [NUM_SOLVERS-1:0]    grant,
    output logic [ROW_W-1:0]          job_row,
    output logic signed [COORD_W-1:0] job_x0,
    output logic signed [COORD_W-1:0] job_y,
    output logic signed [COORD_W-1:0] job_dx,
    output logic                      busy,
    output logic                      frame_done,
    output logic [31:0]               solve_time,
    output logic                      protocol_err
);

    localparam int PW = $clog2(NUM_SOLVERS);

    if (NUM_SOLVERS < 2 || NUM_SOLVERS > 32 || HEIGHT < 1 || HEIGHT > 1023 || WIDTH < 1) begin : g_bad_param
        $error("frame_scheduler: parameter out of range");
    end

    state_t                    state, next_state;
    logic [ROW_W-1:0]          next_row;
    logic signed [COORD_W-1:0] y_acc, win_x, win_dx, win_dy;
    logic [NUM_SOLVERS-1:0]    outstanding, eligible, winner;
    logic [PW-1:0]             rr_ptr, win_idx;
    logic                      win_any, accept, do_grant, last_row, bad_done;

    assign eligible = req & ~outstanding;
    assign last_row = (next_row == ROW_W'(HEIGHT - 1));
    assign bad_done = (state != S_IDLE) && |(row_done & ~outstanding);

    rr_arbiter #(.N(NUM_SOLVERS), .PW(PW)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .winner   (winner),
        .index    (win_idx),
        .any      (win_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        do_grant   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept     = 1'b1;
                next_state = S_DISPATCH;
            end
            S_DISPATCH: if (win_any) begin
                do_grant = 1'b1;
                if (last_row) next_state = S_DRAIN;
            end
            // dones arriving this cycle count as already retired
            S_DRAIN: if ((outstanding & ~row_done) == '0) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
            accept     = 1'b0;
            do_grant   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant        <= '0;
            job_row      <= '0;
            job_x0       <= '0;
            job_y        <= '0;
            job_dx       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            solve_time   <= '0;
            protocol_err <= 1'b0;
            next_row     <= '0;
            y_acc        <= '0;
            win_x        <= '0;
            win_dx       <= '0;
            win_dy       <= '0;
            outstanding  <= '0;
            rr_ptr       <= '0;
        end else begin
            grant      <= '0;
            frame_done <= (state == S_DONE) && !abort;
            // busy stays up through the frame_done cycle
            busy       <= (next_state != S_IDLE) || ((state == S_DONE) && !abort);

            if (accept)
                solve_time <= '0;
            else if (busy && solve_time != 32'hFFFF_FFFF)
                solve_time <= solve_time + 32'd1;

            if (bad_done) protocol_err <= 1'b1;

            if (accept || abort)
                outstanding <= '0;
            else if (state != S_IDLE)
                outstanding <= (outstanding & ~row_done) | (do_grant ? winner : '0);

            if (accept) begin
                win_x    <= min_x;
                win_dx   <= dx;
                win_dy   <= dy;
                y_acc    <= min_y;
                next_row <= '0;
                rr_ptr   <= '0;
            end else if (do_grant) begin
                grant    <= winner;
                job_row  <= next_row;
                job_y    <= y_acc;
                job_x0   <= win_x;
                job_dx   <= win_dx;
                next_row <= next_row + ROW_W'(1);
                y_acc    <= y_acc + win_dy;
                rr_ptr   <= (win_idx == PW'(NUM_SOLVERS - 1)) ? '0 : win_idx + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: expected jobs are queued at start and
// compared as grants appear; small solver model issues row_done pulses.
module tb_frame_scheduler;

    localparam int NS = 10;
    localparam int H  = 12;
    localparam int CW = 27;
    localparam int MAX_CYC = 2000;

    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic signed [CW-1:0] min_x = '0, min_y = '0, dx = '0, dy = '0;
    logic [NS-1:0] req = '0, row_done = '0;
    logic [NS-1:0] grant;
    logic [9:0] job_row;
    logic signed [CW-1:0] job_x0, job_y, job_dx;
    logic busy, frame_done, protocol_err;
    logic [31:0] solve_time;

    int n_checks = 0, n_pass = 0;

    typedef struct {
        int row;
        logic signed [CW-1:0] y;
        logic signed [CW-1:0] x0;
        logic signed [CW-1:0] ddx;
        int solver;
    } exp_t;

    exp_t sb[$];
    int pend[NS];
    logic signed [CW-1:0] first_y[4];
    int grants, dones, fd_cyc, last_done_cyc, first_g, last_g;

    frame_scheduler #(.NUM_SOLVERS(NS), .WIDTH(640), .HEIGHT(H), .COORD_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
        .req(req), .row_done(row_done), .grant(grant), .job_row(job_row),
        .job_x0(job_x0), .job_y(job_y), .job_dx(job_dx), .busy(busy),
        .frame_done(frame_done), .solve_time(solve_time), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    // mode 0: every row to solver 0; 1: row r to solver r%NS; else solver unchecked
    task automatic start_frame(input logic signed [CW-1:0] mx, my, ddx, ddy, input int mode);
        exp_t e;
        for (int r = 0; r < H; r++) begin
            e.row    = r;
            e.y      = my + CW'(r) * ddy;
            e.x0     = mx;
            e.ddx    = ddx;
            e.solver = (mode == 0) ? 0 : (mode == 1) ? r % NS : -1;
            sb.push_back(e);
        end
        min_x = mx; min_y = my; dx = ddx; dy = ddy; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [NS-1:0] mask, input bit hold, input int lat, input int stop_after);
        int cyc, s;
        bit fin;
        exp_t e;
        grants = 0; dones = 0; fd_cyc = -1; last_done_cyc = -1; first_g = -1; last_g = -1;
        for (int i = 0; i < NS; i++) pend[i] = 0;
        cyc = 0; fin = 1'b0;
        req = mask;
        while (!fin) begin
            s = -1;
            if (grant != '0) begin
                for (int i = 0; i < NS; i++) if (grant[i]) s = i;
                n_checks++;
                if (!$onehot(grant) || pend[s] != 0)
                    $display("FAIL grant_free_onehot: grant=%b pending=%0d, required one-hot to an idle solver", grant, pend[s]);
                else n_pass++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_grant: grant=%b row=%0d, required no grant", grant, job_row);
                end else begin
                    e = sb.pop_front();
                    if (job_row !== 10'(e.row) || job_y !== e.y || job_x0 !== e.x0 || job_dx !== e.ddx ||
                        (e.solver >= 0 && s != e.solver))
                        $display("FAIL job: row=%0d y=%0d x0=%0d dx=%0d solver=%0d, required row=%0d y=%0d x0=%0d dx=%0d solver=%0d",
                                 job_row, job_y, job_x0, job_dx, s, e.row, e.y, e.x0, e.ddx, e.solver);
                    else n_pass++;
                end
                if (grants < 4) first_y[grants] = job_y;
                if (first_g < 0) first_g = cyc;
                last_g = cyc;
                grants++;
            end
            if (frame_done) begin dones++; fd_cyc = cyc; end
            if (dones > 0 || (stop_after > 0 && grants == stop_after)) begin
                fin = 1'b1;
            end else if (cyc >= MAX_CYC) begin
                n_checks++;
                $display("FAIL frame_timeout: grants=%0d after %0d cycles, required frame_done", grants, cyc);
                fin = 1'b1;
            end else begin
                row_done = '0;
                for (int i = 0; i < NS; i++)
                    if (pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) begin row_done[i] = 1'b1; last_done_cyc = cyc; end
                    end
                if (s >= 0) pend[s] = lat;
                for (int i = 0; i < NS; i++) req[i] = mask[i] && (hold || pend[i] == 0);
                @(negedge clock);
                cyc++;
            end
        end
        req = '0;
        row_done = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (grant !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || job_row !== '0 || job_x0 !== '0 ||
            job_y !== '0 || job_dx !== '0 || solve_time !== '0 || protocol_err !== 1'b0)
            $display("FAIL reset_values: grant=%b busy=%b done=%b row=%0d x0=%0d y=%0d dx=%0d t=%0d perr=%b, required all zero",
                     grant, busy, frame_done, job_row, job_x0, job_y, job_dx, solve_time, protocol_err);
        else n_pass++;
        reset_n = 1'b1;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_over_start: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_single();
        int ref_y[4];
        ref_y = '{-1048576, -1044207, -1039838, -1035469};
        start_frame(-27'sd2097152, -27'sd1048576, 27'sd3277, 27'sd4369, 0);
        n_checks++;
        if (busy !== 1'b1 || grant !== '0) $display("FAIL start_latency: busy=%b grant=%b, required busy=1 grant=0", busy, grant);
        else n_pass++;
        run_frame(10'b1, 1'b0, 3, 0);
        n_checks++;
        if (first_g !== 1) $display("FAIL first_grant_cycle: got %0d, required 1", first_g);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (first_y[i] !== CW'(ref_y[i])) $display("FAIL single_job_y%0d: got %0d, required %0d", i, first_y[i], ref_y[i]);
            else n_pass++;
        end
        n_checks++;
        if (dones !== 1 || grants !== H || sb.size() !== 0)
            $display("FAIL single_frame: dones=%0d grants=%0d left=%0d, required 1/%0d/0", dones, grants, sb.size(), H);
        else n_pass++;
        n_checks++;
        if (fd_cyc !== last_done_cyc + 2 || busy !== 1'b1)
            $display("FAIL done_latency: frame_done at %0d busy=%b, required %0d busy=1", fd_cyc, busy, last_done_cyc + 2);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || solve_time !== 32'(fd_cyc + 1) || job_row !== 10'(H - 1))
            $display("FAIL single_end: done=%b busy=%b t=%0d row=%0d, required 0/0/%0d/%0d",
                     frame_done, busy, solve_time, job_row, fd_cyc + 1, H - 1);
        else n_pass++;
    endtask

    task automatic test_rotation();
        start_frame(27'sd1000, -27'sd5000, 27'sd7, 27'sd333, 1);
        run_frame('1, 1'b1, 3, 0);
        n_checks++;
        if (dones !== 1 || grants !== H || sb.size() !== 0 || last_g - first_g !== H - 1)
            $display("FAIL rotation: dones=%0d grants=%0d left=%0d span=%0d, required 1/%0d/0/%0d",
                     dones, grants, sb.size(), last_g - first_g, H, H - 1);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_wrap();
        start_frame(27'sd0, 27'sh3F00000, -27'sd1, 27'sh0100000, -1);
        run_frame(10'b11, 1'b0, 2, 0);
        n_checks++;
        if (dones !== 1 || sb.size() !== 0) $display("FAIL wrap: dones=%0d left=%0d, required 1/0", dones, sb.size());
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_protocol();
        start_frame(27'sd1, 27'sd2, 27'sd3, 27'sd4, -1);
        n_checks++;
        if (protocol_err !== 1'b0) $display("FAIL perr_before: got %b, required 0", protocol_err);
        else n_pass++;
        row_done = 10'b1 << 3;
        @(negedge clock);
        row_done = '0;
        n_checks++;
        if (protocol_err !== 1'b1) $display("FAIL perr_set: got %b, required 1", protocol_err);
        else n_pass++;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (protocol_err !== 1'b1 || busy !== 1'b0) $display("FAIL perr_sticky: perr=%b busy=%b, required 1/0", protocol_err, busy);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_start_busy();
        start_frame(27'sd111, 27'sd222, 27'sd333, 27'sd444, 0);
        min_x = 27'sd9999; min_y = -27'sd9999; dx = 27'sd55; dy = 27'sd66; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || solve_time !== 32'd1) $display("FAIL start_busy: busy=%b t=%0d, required 1/1", busy, solve_time);
        else n_pass++;
        run_frame(10'b1, 1'b0, 2, 0);
        n_checks++;
        if (dones !== 1 || sb.size() !== 0) $display("FAIL start_busy_frame: dones=%0d left=%0d, required 1/0", dones, sb.size());
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_abort();
        int nfd;
        logic [31:0] frozen;
        start_frame(27'sd10, 27'sd20, 27'sd30, 27'sd40, 1);
        run_frame('1, 1'b0, 8, 5);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        frozen = 32'(last_g + 1);
        n_checks++;
        if (busy !== 1'b0 || grant !== '0 || solve_time !== frozen)
            $display("FAIL abort: busy=%b grant=%b t=%0d, required 0/0/%0d", busy, grant, solve_time, frozen);
        else n_pass++;
        nfd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (frame_done) nfd++;
        end
        n_checks++;
        if (nfd !== 0 || solve_time !== frozen) $display("FAIL abort_frozen: done_pulses=%0d t=%0d, required 0/%0d", nfd, solve_time, frozen);
        else n_pass++;
        sb.delete();
        start_frame(-27'sd77, 27'sd88, 27'sd5, -27'sd9, 0);
        n_checks++;
        if (solve_time !== 32'd0) $display("FAIL restart_time: t=%0d, required 0", solve_time);
        else n_pass++;
        run_frame(10'b1, 1'b0, 2, 0);
        n_checks++;
        if (dones !== 1 || grants !== H || sb.size() !== 0)
            $display("FAIL restart_frame: dones=%0d grants=%0d left=%0d, required 1/%0d/0", dones, grants, sb.size(), H);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_reset_drain();
        start_frame(-27'sd2097152, 27'sd123, 27'sd456, 27'sd789, 0);
        run_frame(10'b1, 1'b0, 6, H);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || job_row !== '0 || job_x0 !== '0 ||
            job_y !== '0 || job_dx !== '0 || solve_time !== '0 || protocol_err !== 1'b0)
            $display("FAIL async_reset: grant=%b busy=%b done=%b row=%0d x0=%0d y=%0d dx=%0d t=%0d perr=%b, required all zero",
                     grant, busy, frame_done, job_row, job_x0, job_y, job_dx, solve_time, protocol_err);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        @(negedge clock);
        start_frame(27'sd5, 27'sd6, 27'sd7, 27'sd8, 1);
        run_frame('1, 1'b1, 3, 0);
        n_checks++;
        if (dones !== 1 || grants !== H || sb.size() !== 0)
            $display("FAIL post_reset_frame: dones=%0d grants=%0d left=%0d, required 1/%0d/0", dones, grants, sb.size(), H);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_protocol();
        test_start_busy();
        test_abort();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Work scheduler that sequences one fractal frame across the solver array: it latches the view window, hands out image rows one at a time to whichever of NUM_SOLVERS solvers is idle via round-robin arbitration, tracks outstanding rows, and signals frame completion with a cycle-accurate solve time. It sits between the HPS view registers and the solver array, replacing fixed per-solver pixel partitioning with dynamic row dispatch.

## Interface
- NUM_SOLVERS, 10, number of requesting solvers (2..32)
- WIDTH, 640, pixels per row (informational, forwarded in job)
- HEIGHT, 480, rows per frame (1..1023)
- COORD_W, 27, fixed-point coordinate width (signed, 20 fractional bits)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  cancel current frame
- min_x, min_y, dx, dy  in  COORD_W each  view window; latched on accepted start
- req  in  NUM_SOLVERS  solver i idle and wants a row
- row_done  in  NUM_SOLVERS  one-cycle pulse: solver i finished its row
- grant  out  NUM_SOLVERS  one-hot, one-cycle job hand-off
- job_row  out  10  row index of granted job
- job_x0  out  COORD_W  latched min_x
- job_y  out  COORD_W  min_y + job_row*dy
- job_dx  out  COORD_W  latched dx
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse
- solve_time  out  32  cycles of last/current frame
- protocol_err  out  1  sticky: row_done from solver with nothing outstanding

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: start=1 -> latch window, next_row=0, y_acc=min_y, outstanding=0, rr_ptr=0, solve_time=0, go DISPATCH.
- DISPATCH: eligible = req & ~outstanding. If nonzero, pick first set bit searching from rr_ptr upward with wrap; register grant, job_row=next_row, job_y=y_acc; set outstanding[i]; next_row++; y_acc += dy; rr_ptr = (i+1) mod NUM_SOLVERS. Max one grant per cycle. After row HEIGHT-1 granted -> DRAIN.
- DRAIN: wait until outstanding==0 (including clears this cycle) -> DONE.
- DONE: frame_done=1 for one cycle, -> IDLE.
- row_done[i] clears outstanding[i] in any non-IDLE state; a row_done[i] with outstanding[i]=0 is ignored and sets protocol_err (cleared only by reset).
- Grant and row_done to the same solver in one cycle: the grant wins (bit set; the done had already cleared previous job before arbitration used registered outstanding — eligibility uses registered outstanding, so solver not eligible that cycle).
- abort in any non-IDLE state -> IDLE next cycle, outstanding cleared, no frame_done, solve_time frozen. abort has priority over start.
- start while busy ignored. Simultaneous row_done on multiple solvers all honoured.
- y_acc arithmetic: COORD_W-bit two's complement, wraps modulo 2^COORD_W, no saturation.
- solve_time: +1 each cycle busy=1, saturates at 32'hFFFFFFFF, held in IDLE until next accepted start.

## Timing
- Reset values: grant=0, job_row=0, job_x0/job_y/job_dx=0, busy=0, frame_done=0, solve_time=0, protocol_err=0, state IDLE.
- start at cycle t -> busy=1 at t+1; earliest grant at t+2 (req sampled at t+1).
- req sampled cycle t -> grant/job_* registered valid in t+1 only; job_* hold until next grant.
- Solver must drop req the cycle after its grant; req held longer is harmless (outstanding masks it).
- Last row_done sampled at cycle t -> frame_done at t+2 (DRAIN->DONE at t+1 edge registers pulse), busy=0 at t+3.
- Throughput: one row per cycle when requesters available.

## Structure
- Shared package: state enum, COORD_FRAC=20, coordinate typedef of COORD_W bits.
- One sub-module: rr_arbiter (parameter N; inputs eligible, ptr; outputs one-hot winner, index, any).

## Test plan
- Single solver, HEIGHT=4, min_y=-1<<20, dy=4369 -> 4 grants, job_y = -1048576, -1044207, -1039838, -1035469; frame_done once.
- All 10 req held high -> grants rotate solver 0,1,...,9,0 each cycle as dones arrive; no solver gets two outstanding rows.
- row_done on solver 3 with outstanding[3]=0 -> protocol_err=1, stays 1 until reset_n low.
- abort mid-DISPATCH after 5 grants -> IDLE next cycle, no frame_done, solve_time frozen, new start restarts at row 0.
- start asserted while busy -> ignored; window registers unchanged.
- reset_n low mid-DRAIN -> all outputs to reset values immediately (asynchronous), next start runs full frame.
